mux16_rr_arbiter: RTL and testbench



---
 rtl/mux16_rr_arbiter_pkg.sv | 19 +
 rtl/mux16_rr_arbiter_rr_grant2.sv | 15 +
 rtl/mux16_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin packet arbiter.
// State codes, source ids and the beat-counter sizing helper live here.
package mux16_rr_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t GRANT_A = 2'd1;
  localparam state_t GRANT_B = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Counter must hold values 0..MAX_BEATS-1 with headroom for the cap compare.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_rr_grant2.sv
// Two-way round-robin grant: one-hot result, prio breaks ties.
// Purely combinational; only consulted while the arbiter is idle.
module rr_grant2
  import mux16_rr_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       prio,
  output logic [1:0] grant
);

  assign grant[0] = req_a & (~req_b | (prio == SRC_A));
  assign grant[1] = req_b & (~req_a | (prio == SRC_B));

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one registered output stage
// between requesters A and B; a grant ends on last or at the beat cap.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel
);

  localparam int CW = cnt_width(MAX_BEATS);
  localparam logic [CW-1:0] CAP_LAST = CW'(MAX_BEATS - 1);

  state_t          state_reg, state_next;
  logic            prio_reg, prio_next;
  logic            sel_reg, sel_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_last_reg;
  logic             out_src_reg;

  logic             load_en;
  logic             accept;
  logic             cur_last;
  logic             beat_last;
  logic [WIDTH-1:0] mux_data;
  logic [1:0]       grant;

  rr_grant2 u_grant (
    .req_a (a_valid),
    .req_b (b_valid),
    .prio  (prio_reg),
    .grant (grant)
  );

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      prio_reg     <= SRC_A;
      sel_reg      <= SRC_A;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      prio_reg     <= prio_next;
      sel_reg      <= sel_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Next-state: sel follows the owner chosen on leaving IDLE and holds otherwise.
  always_comb begin
    state_next    = state_reg;
    prio_next     = prio_reg;
    sel_next      = sel_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant[0]) begin
          state_next = GRANT_A;
          sel_next   = SRC_A;
        end else if (grant[1]) begin
          state_next = GRANT_B;
          sel_next   = SRC_B;
        end
      end
      GRANT_A, GRANT_B: begin
        if (accept) begin
          if (beat_last) begin
            state_next    = IDLE;
            prio_next     = (state_reg == GRANT_A) ? SRC_B : SRC_A;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath select.
  always_comb begin
    load_en   = ~out_valid_reg | out_ready;
    a_ready   = (state_reg == GRANT_A) & load_en;
    b_ready   = (state_reg == GRANT_B) & load_en;
    accept    = (a_valid & a_ready) | (b_valid & b_ready);
    mux_data  = sel_reg ? b_data : a_data;
    cur_last  = sel_reg ? b_last : a_last;
    beat_last = cur_last | (beat_cnt_reg == CAP_LAST);
  end

  // Single output stage: a new beat may replace a draining one in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= SRC_A;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= mux_data;
      out_last_reg  <= beat_last;
      out_src_reg   <= sel_reg;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_src   = out_src_reg;
  assign sel       = sel_reg;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios with literal beat-order
// expectations, then random traffic checked cycle by cycle against a model.
module tb_mux16_rr_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0, a_last = 1'b0;
  logic [15:0] a_data = 16'h0;
  logic        b_valid = 1'b0, b_last = 1'b0;
  logic [15:0] b_data = 16'h0;
  logic        out_ready = 1'b1;
  logic        a_ready, b_ready, out_valid, out_last, out_src, sel;
  logic [15:0] out_data;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = 0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux16_rr_arbiter #(.WIDTH(16), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready), .sel(sel)
  );

  // Behavioural model: who owns the channel, how many beats it has sent,
  // whose turn it is on a tie, and what the output slot holds.
  typedef struct packed {
    logic        has;
    logic        own;
    logic        prio;
    logic [7:0]  cnt;
    logic        sel;
    logic        ov;
    logic [15:0] od;
    logic        ol;
    logic        os;
  } model_t;

  model_t m = '0;

  function automatic model_t step(model_t s, logic av, logic [15:0] ad, logic al,
                                  logic bv, logic [15:0] bd, logic bl, logic ordy);
    model_t n = s;
    logic room = !s.ov || ordy;
    logic want, fin;
    if (!s.has) begin
      if (ordy) n.ov = 1'b0;
      if (av || bv) begin
        n.has = 1'b1;
        n.own = (av && bv) ? s.prio : bv;
        n.sel = n.own;
      end
    end else begin
      want = s.own ? bv : av;
      if (want && room) begin
        fin   = (s.own ? bl : al) || (int'(s.cnt) + 1 == MAXB);
        n.ov  = 1'b1;
        n.od  = s.own ? bd : ad;
        n.ol  = fin;
        n.os  = s.own;
        n.cnt = s.cnt + 8'd1;
        if (fin) begin
          n.has  = 1'b0;
          n.prio = ~s.own;
          n.cnt  = 8'd0;
        end
      end else if (ordy) begin
        n.ov = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("a_ready",   32'(a_ready),   32'(m.has && !m.own && (!m.ov || out_ready)));
      chk("b_ready",   32'(b_ready),   32'(m.has &&  m.own && (!m.ov || out_ready)));
      chk("out_valid", 32'(out_valid), 32'(m.ov));
      chk("out_data",  32'(out_data),  32'(m.od));
      chk("out_last",  32'(out_last),  32'(m.ol));
      chk("out_src",   32'(out_src),   32'(m.os));
      chk("sel",       32'(sel),       32'(m.sel));
    end
  end

  // Log of beats consumed by the sink.
  typedef struct packed {
    logic        src;
    logic        last;
    logic [15:0] data;
    logic [31:0] cyc;
  } ent_t;
  ent_t log_q[$];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      log_q.push_back({out_src, out_last, out_data, cyc});
      $display("beat cyc=%0d src=%0d last=%0d data=%h", cyc, out_src, out_last, out_data);
    end
  end

  task automatic chk_log(input string tag, input int idx, input logic src,
                         input logic last, input logic [15:0] data);
    if (idx >= log_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d] actual=no_beat required=%h", tag, idx, {src, last, data});
    end else begin
      chk($sformatf("%s[%0d]", tag, idx),
          32'({log_q[idx].src, log_q[idx].last, log_q[idx].data}), 32'({src, last, data}));
    end
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_last = 1'b0; a_data = 16'h0;
    b_valid = 1'b0; b_last = 1'b0; b_data = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_a_ready",   32'(a_ready),   32'd0);
    chk("rst_b_ready",   32'(b_ready),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    log_q.delete();
  endtask

  // Present one beat and hold it until accepted (called just after a posedge).
  task automatic send(input int side, input logic [15:0] d, input logic l);
    logic r;
    int   n = 0;
    if (side == 0) begin a_valid = 1'b1; a_data = d; a_last = l; end
    else           begin b_valid = 1'b1; b_data = d; b_last = l; end
    forever begin
      @(negedge clk);
      r = (side == 0) ? a_ready : b_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout side=%0d actual=not_accepted required=%h", side, d);
        break;
      end
    end
  endtask

  logic [31:0] t0;

  initial begin
    do_reset();

    // Single 3-beat packet from A.
    t0 = cyc;
    send(0, 16'h1111, 1'b0);
    send(0, 16'h2222, 1'b0);
    send(0, 16'h3333, 1'b1);
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("single_count", 32'(log_q.size()), 32'd3);
    chk_log("single", 0, 1'b0, 1'b0, 16'h1111);
    chk_log("single", 1, 1'b0, 1'b0, 16'h2222);
    chk_log("single", 2, 1'b0, 1'b1, 16'h3333);
    if (log_q.size() > 0) chk("single_latency", log_q[0].cyc - t0, 32'd2);

    // Tie: both keep offering single-beat packets.
    do_reset();
    fork
      begin send(0, 16'hAAAA, 1'b1); send(0, 16'hAAAA, 1'b1); a_valid = 1'b0; end
      begin send(1, 16'hBBBB, 1'b1); send(1, 16'hBBBB, 1'b1); b_valid = 1'b0; end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("tie_count", 32'(log_q.size()), 32'd4);
    chk_log("tie", 0, 1'b0, 1'b1, 16'hAAAA);
    chk_log("tie", 1, 1'b1, 1'b1, 16'hBBBB);
    chk_log("tie", 2, 1'b0, 1'b1, 16'hAAAA);
    chk_log("tie", 3, 1'b1, 1'b1, 16'hBBBB);

    // Packet lock: A stalls mid-packet while B waits.
    do_reset();
    fork
      begin
        send(0, 16'hA001, 1'b0);
        send(0, 16'hA002, 1'b0);
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(0, 16'hA003, 1'b0);
        send(0, 16'hA004, 1'b1);
        a_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send(1, 16'hB001, 1'b1);
        b_valid = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("lock_count", 32'(log_q.size()), 32'd5);
    chk_log("lock", 0, 1'b0, 1'b0, 16'hA001);
    chk_log("lock", 1, 1'b0, 1'b0, 16'hA002);
    chk_log("lock", 2, 1'b0, 1'b0, 16'hA003);
    chk_log("lock", 3, 1'b0, 1'b1, 16'hA004);
    chk_log("lock", 4, 1'b1, 1'b1, 16'hB001);

    // Backpressure: sink stalls with 0x1234 held.
    do_reset();
    out_ready = 1'b0;
    fork
      begin send(0, 16'h1234, 1'b0); send(0, 16'h5678, 1'b1); a_valid = 1'b0; end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("bp_seen_valid", 32'(out_valid), 32'd1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_data",  32'(out_data),  32'h1234);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_a_ready",    32'(a_ready),   32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_count", 32'(log_q.size()), 32'd2);
    chk_log("bp", 0, 1'b0, 1'b0, 16'h1234);
    chk_log("bp", 1, 1'b0, 1'b1, 16'h5678);

    // Beat cap: B streams without last, A waits its turn.
    do_reset();
    fork
      begin
        for (int i = 1; i <= 6; i++) send(1, 16'(16'hB000 + i), 1'b0);
        b_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        send(0, 16'hA00C, 1'b1);
        a_valid = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("cap_count", 32'(log_q.size()), 32'd7);
    chk_log("cap", 0, 1'b1, 1'b0, 16'hB001);
    chk_log("cap", 1, 1'b1, 1'b0, 16'hB002);
    chk_log("cap", 2, 1'b1, 1'b0, 16'hB003);
    chk_log("cap", 3, 1'b1, 1'b1, 16'hB004);
    chk_log("cap", 4, 1'b0, 1'b1, 16'hA00C);
    chk_log("cap", 5, 1'b1, 1'b0, 16'hB005);
    chk_log("cap", 6, 1'b1, 1'b0, 16'hB006);

    // Reset mid-packet: prio would be B without the reset.
    do_reset();
    send(0, 16'h0101, 1'b1);
    a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(0, 16'h1111, 1'b0);
    a_data = 16'h2222;
    @(negedge clk);
    chk("mid_pre_data", 32'(out_data), 32'h1111);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_data",  32'(out_data),  32'd0);
    chk("mid_sel",       32'(sel),       32'd0);
    chk("mid_a_ready",   32'(a_ready),   32'd0);
    chk("mid_b_ready",   32'(b_ready),   32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    log_q.delete();
    fork
      begin send(0, 16'hC0A0, 1'b1); a_valid = 1'b0; end
      begin send(1, 16'hC0B0, 1'b1); b_valid = 1'b0; end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("mid_count", 32'(log_q.size()), 32'd2);
    chk_log("mid", 0, 1'b0, 1'b1, 16'hC0A0);
    chk_log("mid", 1, 1'b1, 1'b1, 16'hC0B0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      a_valid   = ($urandom_range(0, 9) < 6);
      a_data    = 16'($urandom);
      a_last    = ($urandom_range(0, 3) == 0);
      b_valid   = ($urandom_range(0, 9) < 6);
      b_data    = 16'($urandom);
      b_last    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
